e203_ifu_instr_enc: RTL and testbench

Sequential RV32IMF instruction encoder feeding the IFU IR interface. It accepts field-level commands on a valid/ready port and encodes each into 32-bit instruction words. The LI pseudo-op expands into a two-word LUI+ADDI sequence. Every emitted word decodes through `e203_ifu_minidec` with identical register indices, so the block is the encoding end of the mini-decode path. It is used for debug-mode instruction injection and for self-test instruction streams.

---
 rtl/e203_ifu_instr_enc_pkg.sv | 56 +++++
 rtl/e203_ifu_instr_pack.sv | 39 +++
 rtl/e203_ifu_instr_enc.sv | 213 +++++++++++++++++++++
 tb/tb_e203_ifu_instr_enc.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_ifu_instr_enc_pkg.sv
// Shared constants and types for the IFU instruction encoder slice.
// Holds base opcodes, command-kind encodings, the MULDIV funct7 value,
// the packer format selector and the encoder FSM state type.
package e203_ifu_instr_enc_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_INSTR_SIZE  = 32;

  // Base opcodes (instr[6:0]) used by the encoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] OPC_MADD   = 7'b1000011;

  // cmd_op encodings
  localparam logic [2:0] CMD_OP     = 3'd0;
  localparam logic [2:0] CMD_MULDIV = 3'd1;
  localparam logic [2:0] CMD_FOP    = 3'd2;
  localparam logic [2:0] CMD_FMADD  = 3'd3;
  localparam logic [2:0] CMD_JAL    = 3'd4;
  localparam logic [2:0] CMD_BXX    = 3'd5;
  localparam logic [2:0] CMD_LI     = 3'd6;
  localparam logic [2:0] CMD_RSVD   = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Instruction word layouts understood by the packer
  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_R4 = 3'd1,
    FMT_I  = 3'd2,
    FMT_U  = 3'd3,
    FMT_J  = 3'd4,
    FMT_B  = 3'd5
  } fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } state_e;

  // True when v is representable as a sign-extended 12-bit immediate
  function automatic logic fits_simm12(input logic [E203_XLEN-1:0] v);
    return (&v[E203_XLEN-1:11]) | (~|v[E203_XLEN-1:11]);
  endfunction

  // Reserved rounding-mode values for FP ops
  function automatic logic rm_reserved(input logic [2:0] rm);
    return (rm == 3'b101) | (rm == 3'b110);
  endfunction

endpackage

// File: rtl/e203_ifu_instr_pack.sv
// Field-to-word packer for R, R4, I, U, J and B instruction layouts.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: fmt selects layout; opcode/funct3/funct7/rd/rs1/rs2/rs3/imm are
// the raw fields (imm carries the full byte offset / value, unshifted for
// J and B, upper 20 bits in place for U); instr is the packed word.
module e203_ifu_instr_pack
  import e203_ifu_instr_enc_pkg::*;
(
  input  fmt_e                         fmt,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [E203_RFIDX_WIDTH-1:0]  rd,
  input  logic [E203_RFIDX_WIDTH-1:0]  rs1,
  input  logic [E203_RFIDX_WIDTH-1:0]  rs2,
  input  logic [E203_RFIDX_WIDTH-1:0]  rs3,
  input  logic [E203_XLEN-1:0]         imm,
  output logic [E203_INSTR_SIZE-1:0]   instr
);

  always_comb begin
    instr = '0;
    unique case (fmt)
      FMT_R:  instr = {funct7, rs2, rs1, funct3, rd, opcode};
      // fmt field fixed to 00 (single precision)
      FMT_R4: instr = {rs3, 2'b00, rs2, rs1, funct3, rd, opcode};
      FMT_I:  instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_U:  instr = {imm[31:12], rd, opcode};
      // J layout scatters imm[20:1]; bit 0 is implicit zero
      FMT_J:  instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      // B layout scatters imm[12:1]; bit 0 is implicit zero
      FMT_B:  instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                       imm[4:1], imm[11], opcode};
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/e203_ifu_instr_enc.sv
// Field-level command encoder into RV32IMF words for the IFU IR port; LI
// expands to LUI+ADDI. Latency: word registered, visible 1 cycle after accept.
// Backpressure: cmd_ready = IDLE & (!ir_valid | ir_ready); held in LI2.
// Ports: cmd_* command channel (valid/ready), ir_* word channel
// (valid/ready, ir_last marks final word), err_illegal one-cycle drop
// pulse, emit_cnt wrapping count of consumed words.
module e203_ifu_instr_enc
  import e203_ifu_instr_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [E203_RFIDX_WIDTH-1:0]  cmd_rd,
  input  logic [E203_RFIDX_WIDTH-1:0]  cmd_rs1,
  input  logic [E203_RFIDX_WIDTH-1:0]  cmd_rs2,
  input  logic [E203_RFIDX_WIDTH-1:0]  cmd_rs3,
  input  logic [2:0]                   cmd_funct3,
  input  logic [6:0]                   cmd_funct7,
  input  logic [E203_XLEN-1:0]         cmd_imm,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  output logic [E203_INSTR_SIZE-1:0]   ir_instr,
  output logic                         ir_last,
  output logic                         err_illegal,
  output logic [CNT_W-1:0]             emit_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state, state_nxt;

  logic accept;
  logic consume;

  // First-word field selection
  fmt_e                        w0_fmt;
  logic [6:0]                  w0_opc;
  logic [2:0]                  w0_f3;
  logic [6:0]                  w0_f7;
  logic [E203_RFIDX_WIDTH-1:0] w0_rs1;
  logic [E203_XLEN-1:0]        w0_imm;
  logic                        cmd_illegal;
  logic                        cmd_two;
  logic [E203_XLEN-1:0]        li_sum;

  logic [E203_INSTR_SIZE-1:0]  w0;
  logic [E203_INSTR_SIZE-1:0]  w1;
  logic [E203_INSTR_SIZE-1:0]  li_word;

  assign accept  = cmd_valid & cmd_ready;
  assign consume = ir_valid & ir_ready;

  // Rounding the upper part by +0x800 compensates for ADDI sign-extending lo
  assign li_sum = cmd_imm + 32'h0000_0800;

  always_comb begin
    w0_fmt      = FMT_R;
    w0_opc      = OPC_OP;
    w0_f3       = cmd_funct3;
    w0_f7       = cmd_funct7;
    w0_rs1      = cmd_rs1;
    w0_imm      = cmd_imm;
    cmd_illegal = 1'b0;
    cmd_two     = 1'b0;
    case (cmd_op)
      CMD_OP: begin
        w0_fmt = FMT_R;
        w0_opc = OPC_OP;
      end
      CMD_MULDIV: begin
        w0_fmt = FMT_R;
        w0_opc = OPC_OP;
        w0_f7  = FUNCT7_MULDIV;
      end
      CMD_FOP: begin
        w0_fmt      = FMT_R;
        w0_opc      = OPC_OP_FP;
        cmd_illegal = rm_reserved(cmd_funct3);
      end
      CMD_FMADD: begin
        w0_fmt      = FMT_R4;
        w0_opc      = OPC_MADD;
        cmd_illegal = rm_reserved(cmd_funct3);
      end
      CMD_JAL: begin
        w0_fmt      = FMT_J;
        w0_opc      = OPC_JAL;
        cmd_illegal = cmd_imm[0];
      end
      CMD_BXX: begin
        w0_fmt      = FMT_B;
        w0_opc      = OPC_BRANCH;
        cmd_illegal = cmd_imm[0] | (cmd_funct3 == 3'b010) |
                      (cmd_funct3 == 3'b011);
      end
      CMD_LI: begin
        if (fits_simm12(cmd_imm)) begin
          // ADDI rd, x0, lo
          w0_fmt = FMT_I;
          w0_opc = OPC_OP_IMM;
          w0_f3  = 3'b000;
          w0_rs1 = '0;
        end else begin
          // LUI rd, hi; the ADDI follows only when lo is non-zero
          w0_fmt  = FMT_U;
          w0_opc  = OPC_LUI;
          w0_imm  = {li_sum[E203_XLEN-1:12], 12'h000};
          cmd_two = (cmd_imm[11:0] != 12'h000);
        end
      end
      default: cmd_illegal = 1'b1;
    endcase
  end

  e203_ifu_instr_pack u_pack_w0 (
    .fmt    (w0_fmt),
    .opcode (w0_opc),
    .funct3 (w0_f3),
    .funct7 (w0_f7),
    .rd     (cmd_rd),
    .rs1    (w0_rs1),
    .rs2    (cmd_rs2),
    .rs3    (cmd_rs3),
    .imm    (w0_imm),
    .instr  (w0)
  );

  // Second LI word: ADDI rd, rd, lo
  e203_ifu_instr_pack u_pack_w1 (
    .fmt    (FMT_I),
    .opcode (OPC_OP_IMM),
    .funct3 (3'b000),
    .funct7 (7'b0000000),
    .rd     (cmd_rd),
    .rs1    (cmd_rd),
    .rs2    ({E203_RFIDX_WIDTH{1'b0}}),
    .rs3    ({E203_RFIDX_WIDTH{1'b0}}),
    .imm    (cmd_imm),
    .instr  (w1)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept & ~cmd_illegal & cmd_two) state_nxt = ST_LI2;
      ST_LI2:  if (consume) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (no path from cmd_valid)
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = ~ir_valid | ir_ready;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Output register and pending ADDI latch. In IDLE an accept implies the
  // output slot is empty or being consumed, so it may be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid    <= 1'b0;
      ir_instr    <= '0;
      ir_last     <= 1'b0;
      err_illegal <= 1'b0;
      li_word     <= '0;
    end else begin
      err_illegal <= accept & cmd_illegal;
      if (accept) begin
        if (cmd_illegal) begin
          ir_valid <= 1'b0;
        end else begin
          ir_valid <= 1'b1;
          ir_instr <= w0;
          ir_last  <= ~cmd_two;
          if (cmd_two) li_word <= w1;
        end
      end else if (consume) begin
        if (state == ST_LI2) begin
          ir_instr <= li_word;
          ir_last  <= 1'b1;
        end else begin
          ir_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_cnt <= '0;
    end else if (consume) begin
      emit_cnt <= emit_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_e203_ifu_instr_enc.sv
// Scoreboard bench for e203_ifu_instr_enc: directed test-plan vectors plus
// randomized commands against a reference encoder built from field rules.
module tb_e203_ifu_instr_enc;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2, cmd_rs3;
  logic [2:0]    cmd_funct3;
  logic [6:0]    cmd_funct7;
  logic [31:0]   cmd_imm;
  logic          ir_valid;
  logic          ir_ready;
  logic [31:0]   ir_instr;
  logic          ir_last;
  logic          err_illegal;
  logic [CW-1:0] emit_cnt;

  always #5 clk = ~clk;

  e203_ifu_instr_enc #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rs3     (cmd_rs3),
    .cmd_funct3  (cmd_funct3),
    .cmd_funct7  (cmd_funct7),
    .cmd_imm     (cmd_imm),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_instr    (ir_instr),
    .ir_last     (ir_last),
    .err_illegal (err_illegal),
    .emit_cnt    (emit_cnt)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   passes    = 0;
  int   model_cnt = 0;
  int   exp_err   = 0;
  int   err_seen  = 0;
  int   cyc       = 0;
  bit   rdy_rand  = 1'b0;
  logic rdy_force = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference encoder: expected words straight from the instruction formats
  function automatic void model(input logic [2:0] op, input logic [4:0] rd, rs1, rs2, rs3,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, output int n,
                                output logic [31:0] a, output logic [31:0] b,
                                output bit ill);
    logic [31:0] up;
    int          s;
    n = 1; a = '0; b = '0; ill = 1'b0;
    case (op)
      3'd0: a = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: a = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
      3'd2: if (f3 == 3'd5 || f3 == 3'd6) ill = 1'b1;
            else a = {f7, rs2, rs1, f3, rd, 7'b1010011};
      3'd3: if (f3 == 3'd5 || f3 == 3'd6) ill = 1'b1;
            else a = {rs3, 2'b00, rs2, rs1, f3, rd, 7'b1000011};
      3'd4: if (imm[0]) ill = 1'b1;
            else a = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      3'd5: if (imm[0] || f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else a = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd6: begin
        s = imm;
        if (s >= -2048 && s <= 2047) begin
          a = {imm[11:0], 5'd0, 3'd0, rd, 7'b0010011};
        end else begin
          up = (imm + 32'h800) >> 12;
          a  = {up[19:0], rd, 7'b0110111};
          if (imm[11:0] != 12'd0) begin
            n = 2;
            b = {imm[11:0], rd, 3'd0, rd, 7'b0010011};
          end
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) n = 0;
  endfunction

  // ir_ready driver: updates just after the rising edge
  initial begin
    ir_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ir_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: pops expected words on each handshake, checks stability under stall
  initial begin
    bit          hold_v = 1'b0;
    logic [31:0] hw;
    logic        hl;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (err_illegal) err_seen++;
        if (hold_v && ir_valid) begin
          chk("hold_instr", ir_instr, hw);
          chk("hold_last", {31'd0, ir_last}, {31'd0, hl});
        end
        hold_v = ir_valid && !ir_ready;
        hw = ir_instr;
        hl = ir_last;
        if (ir_valid && ir_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_word", {31'd0, ir_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("word", ir_instr, e.w);
            chk("last", {31'd0, ir_last}, {31'd0, e.last});
            chk("emit_cnt", {28'd0, emit_cnt}, model_cnt % (1 << CW));
            model_cnt++;
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] rd, rs1, rs2, rs3,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int          waitc = 0;
    int          n;
    logic [31:0] a, b;
    bit          ill;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rs3 = rs3;
    cmd_funct3 = f3; cmd_funct7 = f7; cmd_imm = imm;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      model(op, rd, rs1, rs2, rs3, f3, f7, imm, n, a, b, ill);
      if (ill) exp_err++;
      if (n >= 1) sb.push_back('{w: a, last: (n == 1)});
      if (n == 2) sb.push_back('{w: b, last: 1'b1});
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  logic [31:0] rimm;
  logic [31:0] edge_vals[7];
  int          a0;

  initial begin
    edge_vals = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF,
                  32'h7FFFF800, 32'hFFFFFFFF, 32'h80000000};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_rs3 = '0; cmd_funct3 = '0; cmd_funct7 = '0; cmd_imm = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir_instr", ir_instr, 32'd0);
    chk("rst_ir_last", {31'd0, ir_last}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_emit_cnt", {28'd0, emit_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);

    // MULDIV and FMADD vectors, one cycle after accept
    send(3'd1, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'h55, 32'h0);
    #1;
    chk("muldiv_valid", {31'd0, ir_valid}, 32'd1);
    chk("muldiv_instr", ir_instr, 32'h022081B3);
    chk("muldiv_last", {31'd0, ir_last}, 32'd1);
    send(3'd3, 5'd1, 5'd2, 5'd3, 5'd4, 3'd7, 7'h2A, 32'h0);
    #1;
    chk("fmadd_instr", ir_instr, 32'h203170C3);
    chk("fmadd_frs1", {27'd0, ir_instr[19:15]}, 32'd2);
    chk("fmadd_frs2", {27'd0, ir_instr[24:20]}, 32'd3);
    chk("fmadd_frs3", {27'd0, ir_instr[31:27]}, 32'd4);
    chk("fmadd_r4op", {25'd0, ir_instr[6:0]}, 32'h43);
    idle();
    drain("drain_fmadd");

    // Two-word LI under a 3-cycle stall
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    send(3'd6, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    #1;
    chk("li_lui", ir_instr, 32'h123462B7);
    chk("li_lui_last", {31'd0, ir_last}, 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("li2_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("li_lui_held", ir_instr, 32'h123462B7);
    end
    rdy_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("li_addi", ir_instr, 32'hFFF28293);
    chk("li_addi_last", {31'd0, ir_last}, 32'd1);

    // Single-word LI cases
    send(3'd6, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF);
    #1;
    chk("li_addi_only", ir_instr, 32'h7FF00293);
    send(3'd6, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000);
    #1;
    chk("li_lui_only", ir_instr, 32'h000102B7);
    chk("li_lui_only_last", {31'd0, ir_last}, 32'd1);

    // Illegal commands, the first one landing on a consume
    send(3'd5, 5'd1, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'h8);
    #1;
    chk("bxx_err", {31'd0, err_illegal}, 32'd1);
    chk("bxx_no_valid", {31'd0, ir_valid}, 32'd0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3);
    #1;
    chk("jal_err", {31'd0, err_illegal}, 32'd1);
    chk("jal_no_valid", {31'd0, ir_valid}, 32'd0);
    chk("illegal_cnt_hold", {28'd0, emit_cnt}, model_cnt % (1 << CW));
    idle();
    @(posedge clk);
    #1;
    chk("err_one_cycle", {31'd0, err_illegal}, 32'd0);

    // Reset in LI2 discards the pending ADDI
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    send(3'd6, 5'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE123);
    idle();
    #3;
    rst_n = 1'b0;
    sb.delete();
    model_cnt = 0;
    #1;
    chk("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("mid_rst_instr", ir_instr, 32'd0);
    chk("mid_rst_last", {31'd0, ir_last}, 32'd0);
    chk("mid_rst_cnt", {28'd0, emit_cnt}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    rdy_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("no_addi_after_rst", {31'd0, ir_valid}, 32'd0);
    end

    // Back-to-back OPs across the counter wrap
    a0 = 0;
    for (int i = 0; i < 20; i++) begin
      send(3'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 3'($urandom),
           7'($urandom), 32'd0);
      #1;
      if (i == 0) a0 = cyc;
      chk("tput_valid", {31'd0, ir_valid}, 32'd1);
      if (i == 19) chk("tput_cycles", cyc - a0, 19);
    end
    idle();
    drain("drain_wrap");
    #1;
    chk("wrap_cnt", {28'd0, emit_cnt}, 32'd4);

    // Randomized mix with random downstream stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: rimm = {{20{1'($urandom)}}, 12'($urandom)};
        1: rimm = $urandom & 32'hFFFFF000;
        2: rimm = edge_vals[$urandom_range(0, 6)];
        default: rimm = $urandom;
      endcase
      if ($urandom_range(0, 7) != 0 && $urandom_range(0, 1) == 0) rimm[0] = 1'b0;
      send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), rimm);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    drain("drain_random");
    repeat (3) @(posedge clk);
    chk("err_count", err_seen, exp_err);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
